// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and register-file constants.
package mips_pkg;

    localparam int REG_IDX_W = 5;
    localparam int WORD_W    = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [WORD_W-1:0]    word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_GP   = 5'd28;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;

    localparam word_t SP_RESET = 32'h7FFF_EFFC;
    localparam word_t GP_RESET = 32'h1000_8000;

endpackage

// File: rtl/register_en.sv
// N_BITS register with load enable and asynchronous active-low reset to RESET_VALUE.
module register_en #(
    parameter int                N_BITS      = 32,
    parameter logic [N_BITS-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [N_BITS-1:0] d_i,
    output logic [N_BITS-1:0] q_o
);

    logic [N_BITS-1:0] data_d;
    logic [N_BITS-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/register_file.sv
// 32 x 32 MIPS register file: two combinational read ports, one synchronous write port, $zero hardwired.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file
    import mips_pkg::*;
#(
    parameter int                N_BITS         = WORD_W,
    parameter int                N_REGS         = 32,
    parameter logic [N_BITS-1:0] SP_RESET_VALUE = SP_RESET,
    parameter logic [N_BITS-1:0] GP_RESET_VALUE = GP_RESET
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reg_write_i,
    input  logic [REG_IDX_W-1:0] write_register_i,
    input  logic [N_BITS-1:0]    write_data_i,
    input  logic [REG_IDX_W-1:0] read_register_1_i,
    input  logic [REG_IDX_W-1:0] read_register_2_i,
    output logic [N_BITS-1:0]    read_data_1_o,
    output logic [N_BITS-1:0]    read_data_2_o
);

    logic [N_BITS-1:0] regs [N_REGS];
    logic [N_REGS-1:1] we;

    // One-hot decode gated by reg_write_i, so an X index with writes off selects nothing.
    always_comb begin
        we = '0;
        for (int i = 1; i < N_REGS; i++) begin
            we[i] = reg_write_i && (write_register_i == REG_IDX_W'(i));
        end
    end

    assign regs[0] = '0;

    for (genvar g = 1; g < N_REGS; g++) begin : g_reg
        localparam logic [N_BITS-1:0] RST_VAL =
            (g == int'(REG_SP)) ? SP_RESET_VALUE :
            (g == int'(REG_GP)) ? GP_RESET_VALUE : '0;

        register_en #(
            .N_BITS      (N_BITS),
            .RESET_VALUE (RST_VAL)
        ) u_reg (
            .clk   (clk),
            .rst_n (reset),
            .en_i  (we[g]),
            .d_i   (write_data_i),
            .q_o   (regs[g])
        );
    end

    always_comb begin
        read_data_1_o = regs[read_register_1_i];
        read_data_2_o = regs[read_register_2_i];
`ifdef REGFILE_WRITE_BYPASS_EN
        // Forwarding is suppressed while reset is held so reads show the reset contents.
        if (reset && reg_write_i && (write_register_i != REG_ZERO)) begin
            if (write_register_i == read_register_1_i) begin
                read_data_1_o = write_data_i;
            end
            if (write_register_i == read_register_2_i) begin
                read_data_2_o = write_data_i;
            end
        end
`endif
    end

endmodule
